// File: rtl/led_fader_pkg.sv
// Shared types and default parameters for the LED fader.
package led_fader_pkg;

   localparam int DEF_NUM_LEDS = 8;
   localparam int DEF_PWM_BITS = 8;
   localparam int DEF_TICK_DIV = 50000;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RISE = 2'd1,
      ON   = 2'd2,
      FALL = 2'd3
   } fade_state_t;

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: fade FSM, brightness level and registered PWM compare.
// Define LED_FADER_GAMMA_EN to apply a squared (gamma) brightness curve.
//
// state | meaning
// OFF   | dark, lvl = 0, waiting for req
// RISE  | stepping lvl up by one per tick
// ON    | fully lit, lvl = MAX, waiting for req to drop
// FALL  | stepping lvl down by one per tick
import led_fader_pkg::*;

module led_fader_channel #(
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                req,
   input  logic                tick,
   input  logic                fade_en,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led,
   output logic                ramping
);

   localparam logic [PWM_BITS-1:0] MAX    = '1;
   localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - 1'b1;
   localparam logic [PWM_BITS-1:0] ONE    = PWM_BITS'(1);

   fade_state_t         state;
   logic [PWM_BITS-1:0] lvl;
   logic [PWM_BITS-1:0] duty;

`ifdef LED_FADER_GAMMA_EN
   logic [2*PWM_BITS-1:0] lvl_sq;
   assign lvl_sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
   assign duty   = lvl_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign duty = lvl;
`endif

   assign ramping = (state == RISE) || (state == FALL);

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state <= OFF;
         lvl   <= '0;
         led   <= 1'b0;
      end else begin
         // End points are forced so full-on and full-off never flicker.
         led <= (lvl == MAX) || ((lvl != '0) && (duty > pwm_cnt));
         if (!fade_en) begin
            if (req) begin
               lvl   <= MAX;
               state <= ON;
            end else begin
               lvl   <= '0;
               state <= OFF;
            end
         end else begin
            unique case (state)
               OFF: if (req) state <= RISE;
               RISE: begin
                  if (!req) begin
                     state <= FALL;
                  end else if (tick) begin
                     if (lvl != MAX) lvl <= lvl + 1'b1;
                     if (lvl >= MAX_M1) state <= ON;
                  end
               end
               ON: if (!req) state <= FALL;
               FALL: begin
                  if (req) begin
                     state <= RISE;
                  end else if (tick) begin
                     if (lvl != '0) lvl <= lvl - 1'b1;
                     if (lvl <= ONE) state <= OFF;
                  end
               end
               default: state <= OFF;
            endcase
         end
      end
   end

endmodule

// File: rtl/led_fader.sv
// Multi-channel LED fader: input register, shared fade-step prescaler and PWM
// counter, one led_fader_channel per LED. Optional macro: LED_FADER_GAMMA_EN.
import led_fader_pkg::*;

module led_fader #(
   parameter int NUM_LEDS = DEF_NUM_LEDS,
   parameter int PWM_BITS = DEF_PWM_BITS,
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_LEDS-1:0] leds_in,
   input  logic                fade_en,
   output logic [NUM_LEDS-1:0] leds_out,
   output logic                busy
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [NUM_LEDS-1:0] req;
   logic [PW-1:0]       presc;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick;
   logic [NUM_LEDS-1:0] ramping;

   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         req     <= '0;
         presc   <= '0;
         pwm_cnt <= '0;
         busy    <= 1'b0;
      end else begin
         req     <= leds_in;
         presc   <= tick ? '0 : presc + 1'b1;
         pwm_cnt <= pwm_cnt + 1'b1;
         busy    <= |ramping;
      end
   end

   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_fader_channel #(
         .PWM_BITS(PWM_BITS)
      ) u_ch (
         .clk_clk    (clk_clk),
         .reset_reset(reset_reset),
         .req        (req[i]),
         .tick       (tick),
         .fade_en    (fade_en),
         .pwm_cnt    (pwm_cnt),
         .led        (leds_out[i]),
         .ramping    (ramping[i])
      );
   end

endmodule
